spi_xfer_arbiter: RTL

- Shares one spi_core master between two independent requesters; round-robin arbitration.
- Sequences each transfer: issue write strobe with TX byte, wait for spi_core done, capture RX byte, return response to owning requester.
- Watchdog aborts a transfer whose done never arrives, so a stuck core cannot hang both clients.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_rr_arb2.sv | 20 ++
 rtl/spi_xfer_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI transfer arbiter
package spi_pkg;

  localparam int DWIDTH_DEF  = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/spi_rr_arb2.sv
// rtl/spi_rr_arb2.sv - two-way round-robin grant, purely combinational
module spi_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant_valid = valid0 | valid1;
    // On contention the requester that did not win last time goes next
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else begin
      grant = valid1;
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - shares one spi_core between two requesters with a watchdog
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DWIDTH-1:0] req0_data,
  output logic              rsp0_valid,
  output logic [DWIDTH-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              rsp1_valid,
  output logic [DWIDTH-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic              spi_cs,
  output logic              spi_rd,
  output logic              spi_wr,
  output logic [DWIDTH-1:0] spi_din,
  input  logic [DWIDTH-1:0] spi_dout,
  input  logic              spi_done
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  xfer_state_t       state, state_n;
  logic [DWIDTH-1:0] tx_reg;
  logic [TW-1:0]     timer;
  logic              owner;
  logic              last_grant;
  logic              grant;
  logic              grant_valid;
  logic              timeout_hit;

  spi_rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign timeout_hit = (timer == TIMER_LAST);
  assign spi_rd      = 1'b0;
  assign spi_din     = tx_reg;

  always_comb begin
    state_n    = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    spi_cs     = 1'b0;
    spi_wr     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          req0_ready = ~grant;
          req1_ready = grant;
          state_n    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        spi_cs  = 1'b1;
        spi_wr  = 1'b1;
        state_n = ST_BUSY;
      end
      ST_BUSY: begin
        if (spi_done || timeout_hit) begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_reg     <= '0;
      timer      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            tx_reg     <= grant ? req1_data : req0_data;
            owner      <= grant;
            last_grant <= grant;
          end
        end
        ST_ISSUE: timer <= '0;
        ST_BUSY: begin
          timer <= timer + 1'b1;
          // Response registers are per port so each holds its last value between pulses;
          // a done arriving on the final timer cycle still counts as success
          if (spi_done) begin
            if (owner) begin
              rsp1_data <= spi_dout;
              rsp1_err  <= 1'b0;
            end else begin
              rsp0_data <= spi_dout;
              rsp0_err  <= 1'b0;
            end
          end else if (timeout_hit) begin
            if (owner) begin
              rsp1_data <= '0;
              rsp1_err  <= 1'b1;
            end else begin
              rsp0_data <= '0;
              rsp0_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
